sie_tx_packetizer: RTL and testbench

Device-side SIE transmit packetizer: it turns a packet request and a payload byte stream into the byte sequence of a USB 2.0 full-speed packet. Handshake and other PID-only packets are sent as a single PID byte. Data packets are sent as PID, payload, then CRC16. It sits directly upstream of the PHY transmitter and drives that block's 8-bit valid/ready byte interface, gated at bit rate by the shared `clk_gate_i`.

---
 rtl/sie_tx_packetizer.sv | 158 +++++++++++++++
 tb/tb_sie_tx_packetizer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sie_tx_packetizer.sv
// USB full-speed SIE transmit packetizer: PID-only packets as one byte, data
// packets as PID + payload + complemented CRC16, on a valid/ready byte link.
module sie_tx_packetizer #(
   parameter int MAX_PAYLOAD = 64
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clk_gate_i,
   input  logic       pkt_start_i,
   input  logic [3:0] pid_i,
   input  logic       data_valid_i,
   input  logic [7:0] data_i,
   output logic       data_ready_o,
   output logic       busy_o,
   output logic       tx_valid_o,
   output logic [7:0] tx_data_o,
   input  logic       tx_ready_i
);

   localparam int CW = $clog2(MAX_PAYLOAD + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PAYLOAD);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PID    = 3'd1,
      ST_DATA   = 3'd2,
      ST_CRC_LO = 3'd3,
      ST_CRC_HI = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    pid_q, pid_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   crc_q, crc_d;
   logic [7:0]    byte_q, byte_d;
   logic          tx_valid_q, tx_valid_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          consume_s;
   logic [15:0]   crc_upd_s;

   // Reflected CRC16 (poly 0xA001), eight bit steps, LSB of the byte first.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
      logic [15:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if ((c[0] ^ d[i]) == 1'b1) c = (c >> 1) ^ 16'hA001;
         else                       c = c >> 1;
      end
      return c;
   endfunction

   assign consume_s  = clk_gate_i & tx_valid_q & tx_ready_i;
   assign crc_upd_s  = crc16_byte(crc_q, byte_q);
   assign busy_o     = (state_q != ST_IDLE);
   assign tx_valid_o = tx_valid_q;
   assign tx_data_o  = tx_data_q;

   // Next-state logic; tx_data_d is prepared one byte ahead so the PHY sees no gaps.
   always_comb begin
      state_d      = state_q;
      pid_d        = pid_q;
      cnt_d        = cnt_q;
      crc_d        = crc_q;
      byte_d       = byte_q;
      tx_valid_d   = tx_valid_q;
      tx_data_d    = tx_data_q;
      data_ready_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pkt_start_i) begin
               pid_d      = pid_i;
               cnt_d      = '0;
               crc_d      = 16'hFFFF;
               tx_valid_d = 1'b1;
               tx_data_d  = {~pid_i, pid_i};
               state_d    = ST_PID;
            end else begin
               state_d    = ST_IDLE;
            end
         end
         ST_PID: begin
            if (!consume_s) begin
               state_d = ST_PID;
            end else if (pid_q[1:0] != 2'b11) begin
               tx_valid_d = 1'b0;
               state_d    = ST_IDLE;
            end else if (data_valid_i) begin
               byte_d       = data_i;
               cnt_d        = cnt_q + CNT_ONE;
               data_ready_o = 1'b1;
               tx_data_d    = data_i;
               state_d      = ST_DATA;
            end else begin
               tx_data_d = ~crc_q[7:0];
               state_d   = ST_CRC_LO;
            end
         end
         ST_DATA: begin
            if (!consume_s) begin
               state_d = ST_DATA;
            end else if (data_valid_i && (cnt_q < MAX_CNT)) begin
               crc_d        = crc_upd_s;
               byte_d       = data_i;
               cnt_d        = cnt_q + CNT_ONE;
               data_ready_o = 1'b1;
               tx_data_d    = data_i;
            end else begin
               crc_d     = crc_upd_s;
               tx_data_d = ~crc_upd_s[7:0];
               state_d   = ST_CRC_LO;
            end
         end
         ST_CRC_LO: begin
            if (consume_s) begin
               tx_data_d = ~crc_q[15:8];
               state_d   = ST_CRC_HI;
            end else begin
               state_d   = ST_CRC_LO;
            end
         end
         ST_CRC_HI: begin
            if (consume_s) begin
               tx_valid_d = 1'b0;
               state_d    = ST_IDLE;
            end else begin
               state_d    = ST_CRC_HI;
            end
         end
         default: begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
         end
      endcase
   end

   // State registers advance only on bit-time gated cycles.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         pid_q      <= 4'h0;
         cnt_q      <= '0;
         crc_q      <= 16'hFFFF;
         byte_q     <= 8'h00;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else if (clk_gate_i) begin
         state_q    <= state_d;
         pid_q      <= pid_d;
         cnt_q      <= cnt_d;
         crc_q      <= crc_d;
         byte_q     <= byte_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
      end
   end

endmodule

// File: tb/tb_sie_tx_packetizer.sv
// Scoreboard bench: two packetizers (MAX_PAYLOAD 64 and 4) checked against a
// packet-level reference model; a monitor pops expected bytes on each consume.
module tb_sie_tx_packetizer;

   localparam int MAXA = 64;
   localparam int MAXB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic gate = 1'b0;
   int   gate_cnt = 0;

   logic       pkt_start [2];
   logic [3:0] pid       [2];
   logic       data_valid[2];
   logic [7:0] data      [2];
   logic       tx_ready  [2];
   logic       stall     [2];

   logic       dr0, dr1, bsy0, bsy1, tv0, tv1;
   logic [7:0] td0, td1;
   logic       dr[2], bsy[2], tv[2];
   logic [7:0] td[2];
   assign dr[0] = dr0;   assign dr[1] = dr1;
   assign bsy[0] = bsy0; assign bsy[1] = bsy1;
   assign tv[0] = tv0;   assign tv[1] = tv1;
   assign td[0] = td0;   assign td[1] = td1;

   logic [7:0] exp0[$], exp1[$], pay0[$], pay1[$];
   logic [7:0] none[$];
   int checks = 0;
   int failures = 0;
   int ready_cnt[2];
   int exp_rdy[2];
   int pay_len[2];

   sie_tx_packetizer #(.MAX_PAYLOAD(MAXA)) dut_a (
      .clk_i(clk), .rst_i(rst), .clk_gate_i(gate),
      .pkt_start_i(pkt_start[0]), .pid_i(pid[0]),
      .data_valid_i(data_valid[0]), .data_i(data[0]), .data_ready_o(dr0),
      .busy_o(bsy0), .tx_valid_o(tv0), .tx_data_o(td0), .tx_ready_i(tx_ready[0]));

   sie_tx_packetizer #(.MAX_PAYLOAD(MAXB)) dut_b (
      .clk_i(clk), .rst_i(rst), .clk_gate_i(gate),
      .pkt_start_i(pkt_start[1]), .pid_i(pid[1]),
      .data_valid_i(data_valid[1]), .data_i(data[1]), .data_ready_o(dr1),
      .busy_o(bsy1), .tx_valid_o(tv1), .tx_data_o(td1), .tx_ready_i(tx_ready[1]));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Input driver: bit-rate gate, random PHY back-pressure, payload source.
   always @(negedge clk) begin
      gate_cnt = (gate_cnt + 1) % 4;
      gate = (gate_cnt == 0);
      for (int k = 0; k < 2; k++) begin
         tx_ready[k] = stall[k] ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
      data_valid[0] = (pay0.size() != 0);
      data[0]       = (pay0.size() != 0) ? pay0[0] : 8'h00;
      data_valid[1] = (pay1.size() != 0);
      data[1]       = (pay1.size() != 0) ? pay1[0] : 8'h00;
   end

   // Monitor: compares every consumed byte and every payload pop.
   always @(negedge clk) begin
      logic [7:0] e;
      #2;
      for (int k = 0; k < 2; k++) begin
         if (gate && tv[k] && tx_ready[k]) begin
            if ((k == 0 ? exp0.size() : exp1.size()) == 0) begin
               checks++;
               failures++;
               $display("FAIL tx_byte dut%0d actual=%0h required=<none>", k, td[k]);
            end else begin
               e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
               check($sformatf("tx_byte dut%0d", k), td[k], e);
            end
         end
         if (dr[k]) begin
            check("ready_on_consume", {31'd0, gate & tv[k] & tx_ready[k]}, 32'd1);
            ready_cnt[k]++;
            if (k == 0 && pay0.size() != 0) void'(pay0.pop_front());
            if (k == 1 && pay1.size() != 0) void'(pay1.pop_front());
         end
      end
   end

   task automatic wait_gate();
      @(negedge clk); #1;
      while (!gate) begin @(negedge clk); #1; end
   endtask

   // Builds the expected byte stream (or takes a literal one) and issues the request.
   task automatic start_pkt(input int k, input logic [3:0] p, input logic [7:0] pl[$],
                            input logic [7:0] lit[$]);
      logic [7:0]  q[$];
      logic [15:0] crc;
      int          n;
      int          mx;
      mx = (k == 0) ? MAXA : MAXB;
      n  = (p[1:0] == 2'b11) ? ((pl.size() < mx) ? pl.size() : mx) : 0;
      if (lit.size() != 0) begin
         q = lit;
      end else begin
         q.push_back({~p, p});
         if (p[1:0] == 2'b11) begin
            crc = 16'hFFFF;
            for (int i = 0; i < n; i++) begin
               q.push_back(pl[i]);
               for (int b = 0; b < 8; b++) begin
                  if (crc[0] ^ pl[i][b]) crc = (crc >> 1) ^ 16'hA001;
                  else                   crc = crc >> 1;
               end
            end
            crc = ~crc;
            q.push_back(crc[7:0]);
            q.push_back(crc[15:8]);
         end
      end
      ready_cnt[k] = 0;
      exp_rdy[k]   = n;
      pay_len[k]   = pl.size();
      wait_gate();
      if (k == 0) begin exp0 = q; pay0 = pl; end
      else        begin exp1 = q; pay1 = pl; end
      data_valid[k] = (pl.size() != 0);
      data[k]       = (pl.size() != 0) ? pl[0] : 8'h00;
      pkt_start[k]  = 1'b1;
      pid[k]        = p;
      @(posedge clk); #1;
      pkt_start[k] = 1'b0;
      check("start_tx_valid", {31'd0, tv[k]}, 32'd1);
      check("start_busy", {31'd0, bsy[k]}, 32'd1);
      check("start_pid_byte", {24'd0, td[k]}, {24'd0, ~p, p});
   endtask

   task automatic wait_idle(input int k);
      int n;
      n = 0;
      do begin @(negedge clk); #3; n++; end while (bsy[k] && n < 4000);
      check("idle_timeout", {31'd0, bsy[k]}, 32'd0);
      check("end_tx_valid", {31'd0, tv[k]}, 32'd0);
      check("exp_drained", (k == 0) ? exp0.size() : exp1.size(), 32'd0);
      check("ready_count", ready_cnt[k], exp_rdy[k]);
      check("payload_left", (k == 0) ? pay0.size() : pay1.size(), pay_len[k] - exp_rdy[k]);
      if (k == 0) pay0.delete(); else pay1.delete();
   endtask

   task automatic wait_ready(input int k, input int target);
      int n;
      n = 0;
      while (ready_cnt[k] < target && n < 4000) begin @(negedge clk); #3; n++; end
      check("ready_wait_timeout", {31'd0, ready_cnt[k] >= target}, 32'd1);
   endtask

   initial begin
      logic [7:0] pl[$];
      logic [7:0] lit[$];
      logic       snap_v;
      logic [7:0] snap_d;
      int         k, len, g;
      logic [3:0] p;
      for (int i = 0; i < 2; i++) begin
         pkt_start[i] = 1'b0; pid[i] = 4'h0; data_valid[i] = 1'b0;
         data[i] = 8'h00; tx_ready[i] = 1'b0; stall[i] = 1'b0; ready_cnt[i] = 0;
      end
      #12;
      for (int i = 0; i < 2; i++) begin
         check("rst_tx_valid", {31'd0, tv[i]}, 32'd0);
         check("rst_tx_data", {24'd0, td[i]}, 32'd0);
         check("rst_busy", {31'd0, bsy[i]}, 32'd0);
         check("rst_data_ready", {31'd0, dr[i]}, 32'd0);
      end
      #11 rst = 1'b0;

      // ACK: one byte, no payload consumed
      start_pkt(0, 4'h2, none, '{8'hD2});
      wait_idle(0);
      // DATA0 zero-length
      start_pkt(0, 4'h3, none, '{8'hC3, 8'h00, 8'h00});
      wait_idle(0);
      // DATA1 "123456789", plus an ignored start while busy
      pl  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      lit = '{8'h4B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'hC8, 8'hB4};
      start_pkt(0, 4'hB, pl, lit);
      repeat (3) wait_gate();
      pkt_start[0] = 1'b1; pid[0] = 4'h2;
      @(posedge clk); #1;
      pkt_start[0] = 1'b0;
      wait_idle(0);
      // MAX_PAYLOAD=4 instance, six bytes offered
      pl = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
      start_pkt(1, 4'h3, pl, none);
      wait_idle(1);
      // PHY stall mid-payload
      pl.delete();
      for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
      start_pkt(0, 4'h3, pl, none);
      wait_ready(0, 3);
      stall[0] = 1'b1;
      @(negedge clk); #3;
      snap_v = tv[0];
      snap_d = td[0];
      g = 0;
      while (g < 20) begin
         @(negedge clk); #3;
         if (gate) begin
            g++;
            check("stall_valid", {31'd0, tv[0]}, {31'd0, snap_v});
            check("stall_data", {24'd0, td[0]}, {24'd0, snap_d});
            check("stall_ready", {31'd0, dr[0]}, 32'd0);
         end
      end
      stall[0] = 1'b0;
      wait_idle(0);
      // Reset during DATA, then a clean zero-length packet
      pl.delete();
      for (int i = 0; i < 16; i++) pl.push_back(8'($urandom));
      start_pkt(0, 4'hB, pl, none);
      wait_ready(0, 2);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      check("abort_tx_valid", {31'd0, tv[0]}, 32'd0);
      check("abort_busy", {31'd0, bsy[0]}, 32'd0);
      exp0.delete(); pay0.delete(); exp1.delete(); pay1.delete();
      #5 rst = 1'b0;
      start_pkt(0, 4'h3, none, '{8'hC3, 8'h00, 8'h00});
      wait_idle(0);
      // Randomized packets on both instances
      for (int t = 0; t < 24; t++) begin
         k   = $urandom_range(0, 1);
         p   = 4'($urandom);
         len = $urandom_range(0, 10);
         pl.delete();
         for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
         start_pkt(k, p, pl, none);
         wait_idle(k);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
